// File: rtl/cnn_ci_acc_pkg.sv
// rtl/cnn_ci_acc_pkg.sv - shared types, latency constant and packed-index helpers
// for the CNN input-channel accumulator.
package cnn_ci_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAC_LAT = 2;

  function automatic int calc_ox(input int ix, input int kx);
    return ix - kx + 1;
  endfunction

  function automatic int calc_oy(input int iy, input int ky);
    return iy - ky + 1;
  endfunction

  function automatic int fmap_off(input int c, input int y, input int x,
                                  input int iy, input int ix, input int dl);
    return ((c * iy + y) * ix + x) * dl;
  endfunction

  function automatic int weight_off(input int c, input int ky, input int kx,
                                    input int kyn, input int kxn, input int dl);
    return ((c * kyn + ky) * kxn + kx) * dl;
  endfunction

  function automatic int out_off(input int y, input int x, input int ox, input int al);
    return (y * ox + x) * al;
  endfunction

endpackage

// File: rtl/cnn_ci_acc_seq_if.sv
// rtl/cnn_ci_acc_seq_if.sv - tile-in / result-out handshake bundle of the
// input-channel accumulator.
interface cnn_ci_acc_seq_if #(
  parameter int ICH      = 4,
  parameter int IX       = 7,
  parameter int IY       = 4,
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int DATA_LEN = 8,
  parameter int ACC_LEN  = 24
);
  import cnn_ci_acc_pkg::*;

  localparam int OX = calc_ox(IX, KX);
  localparam int OY = calc_oy(IY, KY);

  logic                             i_soft_reset;
  logic                             i_in_valid;
  logic                             o_in_ready;
  logic [ICH*KY*KX*DATA_LEN-1:0]    i_cnn_weight;
  logic [ICH*IY*IX*DATA_LEN-1:0]    i_in_fmap;
  logic                             o_ot_valid;
  logic                             i_ot_ready;
  logic [OY*OX*ACC_LEN-1:0]         o_ot_ci_acc;
  logic                             o_busy;

  modport master (
    output i_soft_reset, i_in_valid, i_cnn_weight, i_in_fmap, i_ot_ready,
    input  o_in_ready, o_ot_valid, o_ot_ci_acc, o_busy
  );

  modport slave (
    input  i_soft_reset, i_in_valid, i_cnn_weight, i_in_fmap, i_ot_ready,
    output o_in_ready, o_ot_valid, o_ot_ci_acc, o_busy
  );

endinterface

// File: rtl/cnn_ci_mac.sv
// rtl/cnn_ci_mac.sv - two-stage KXxKY signed MAC (products, then adder tree)
// carrying a valid and a window tag alongside the data.
module cnn_ci_mac #(
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int DATA_LEN = 8,
  parameter int ACC_LEN  = 24,
  parameter int TAG_W    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic [KX*KY*DATA_LEN-1:0]   i_fmap,
  input  logic [KX*KY*DATA_LEN-1:0]   i_weight,
  output logic                        o_valid,
  output logic [TAG_W-1:0]            o_tag,
  output logic [ACC_LEN-1:0]          o_sum
);
  localparam int NK = KX * KY;
  localparam int PW = 2 * DATA_LEN;

  logic [NK*PW-1:0]   prod_q, prod_d;
  logic [ACC_LEN-1:0] sum_q, sum_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d;

  always_comb begin
    prod_d = '0;
    sum_d  = '0;
    for (int k = 0; k < NK; k++) begin
      prod_d[k*PW +: PW] = PW'($signed(i_fmap[k*DATA_LEN +: DATA_LEN]))
                         * PW'($signed(i_weight[k*DATA_LEN +: DATA_LEN]));
    end
    for (int k = 0; k < NK; k++) begin
      sum_d = sum_d + ACC_LEN'($signed(prod_q[k*PW +: PW]));
    end
    // A soft clear drops every in-flight window so an aborted tile never lands.
    v1_d   = i_valid & ~i_clear;
    v2_d   = v1_q & ~i_clear;
    tag1_d = i_tag;
    tag2_d = tag1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      sum_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  assign o_valid = v2_q;
  assign o_tag   = tag2_q;
  assign o_sum   = sum_q;

endmodule

// File: rtl/cnn_ci_acc_seq.sv
// rtl/cnn_ci_acc_seq.sv - handshaked input-channel accumulator: FSM, window walk,
// input latches and acc buffer; CNN_CI_ACC_RELU_EN clamps negative outputs to 0.
module cnn_ci_acc_seq
  import cnn_ci_acc_pkg::*;
#(
  parameter int ICH      = 4,
  parameter int IX       = 7,
  parameter int IY       = 4,
  parameter int KX       = 3,
  parameter int KY       = 3,
  parameter int DATA_LEN = 8,
  parameter int ACC_LEN  = 24
) (
  input  logic             clk,
  input  logic             reset,
  cnn_ci_acc_seq_if.slave  bus
);
  localparam int OX    = calc_ox(IX, KX);
  localparam int OY    = calc_oy(IY, KY);
  localparam int NK    = KX * KY;
  localparam int FW    = ICH * IY * IX * DATA_LEN;
  localparam int WW    = ICH * KY * KX * DATA_LEN;
  localparam int RW    = OY * OX * ACC_LEN;
  localparam int ICH_W = (ICH > 1) ? $clog2(ICH) : 1;
  localparam int OY_W  = (OY > 1) ? $clog2(OY) : 1;
  localparam int OX_W  = (OX > 1) ? $clog2(OX) : 1;
  localparam int TAG_W = 1 + OY_W + OX_W;
  localparam int DR_W  = $clog2(MAC_LAT + 1);

  state_t             state_q, state_d;
  logic [ICH_W-1:0]   ich_q, ich_d;
  logic [OY_W-1:0]    oy_q, oy_d;
  logic [OX_W-1:0]    ox_q, ox_d;
  logic [DR_W-1:0]    drain_q, drain_d;
  logic [FW-1:0]      fmap_q, fmap_d;
  logic [WW-1:0]      weight_q, weight_d;
  logic [RW-1:0]      acc_q, acc_d;
  logic [RW-1:0]      ot_acc;

  logic [NK*DATA_LEN-1:0] win_f, win_w;
  logic                   issue, last_win;
  logic                   mac_valid;
  logic [TAG_W-1:0]       mac_tag;
  logic [ACC_LEN-1:0]     mac_sum;
  logic                   m_first;
  logic [OY_W-1:0]        m_oy;
  logic [OX_W-1:0]        m_ox;

  always_comb begin
    win_f = '0;
    win_w = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX; kx++) begin
        win_f[(ky*KX+kx)*DATA_LEN +: DATA_LEN] =
          fmap_q[fmap_off(int'(ich_q), int'(oy_q) + ky, int'(ox_q) + kx, IY, IX, DATA_LEN) +: DATA_LEN];
        win_w[(ky*KX+kx)*DATA_LEN +: DATA_LEN] =
          weight_q[weight_off(int'(ich_q), ky, kx, KY, KX, DATA_LEN) +: DATA_LEN];
      end
    end
  end

  cnn_ci_mac #(
    .KX(KX), .KY(KY), .DATA_LEN(DATA_LEN), .ACC_LEN(ACC_LEN), .TAG_W(TAG_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (bus.i_soft_reset),
    .i_valid  (issue),
    .i_tag    ({ich_q == '0, oy_q, ox_q}),
    .i_fmap   (win_f),
    .i_weight (win_w),
    .o_valid  (mac_valid),
    .o_tag    (mac_tag),
    .o_sum    (mac_sum)
  );

  assign m_first  = mac_tag[TAG_W-1];
  assign m_oy     = mac_tag[OX_W +: OY_W];
  assign m_ox     = mac_tag[OX_W-1:0];
  assign last_win = (ich_q == ICH_W'(ICH - 1)) && (oy_q == OY_W'(OY - 1)) && (ox_q == OX_W'(OX - 1));

  always_comb begin
    state_d  = state_q;
    ich_d    = ich_q;
    oy_d     = oy_q;
    ox_d     = ox_q;
    drain_d  = drain_q;
    fmap_d   = fmap_q;
    weight_d = weight_q;
    acc_d    = acc_q;
    issue    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_in_valid) begin
          fmap_d   = bus.i_in_fmap;
          weight_d = bus.i_cnn_weight;
          acc_d    = '0;
          ich_d    = '0;
          oy_d     = '0;
          ox_d     = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (ox_q == OX_W'(OX - 1)) begin
          ox_d = '0;
          if (oy_q == OY_W'(OY - 1)) begin
            oy_d  = '0;
            ich_d = ich_q + 1'b1;
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
        if (last_win) begin
          ich_d   = '0;
          drain_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DR_W'(MAC_LAT - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ot_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // First-channel results overwrite, so the buffer never needs a separate pre-clear pass.
    if (mac_valid) begin
      if (m_first) begin
        acc_d[out_off(int'(m_oy), int'(m_ox), OX, ACC_LEN) +: ACC_LEN] = mac_sum;
      end else begin
        acc_d[out_off(int'(m_oy), int'(m_ox), OX, ACC_LEN) +: ACC_LEN] =
          acc_q[out_off(int'(m_oy), int'(m_ox), OX, ACC_LEN) +: ACC_LEN] + mac_sum;
      end
    end

    if (bus.i_soft_reset) begin
      state_d  = IDLE;
      ich_d    = '0;
      oy_d     = '0;
      ox_d     = '0;
      drain_d  = '0;
      fmap_d   = '0;
      weight_d = '0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ich_q    <= '0;
      oy_q     <= '0;
      ox_q     <= '0;
      drain_q  <= '0;
      fmap_q   <= '0;
      weight_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      ich_q    <= ich_d;
      oy_q     <= oy_d;
      ox_q     <= ox_d;
      drain_q  <= drain_d;
      fmap_q   <= fmap_d;
      weight_q <= weight_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    ot_acc = acc_q;
`ifdef CNN_CI_ACC_RELU_EN
    for (int i = 0; i < OY * OX; i++) begin
      if (acc_q[i*ACC_LEN + ACC_LEN - 1]) begin
        ot_acc[i*ACC_LEN +: ACC_LEN] = '0;
      end
    end
`else
`endif
  end

  assign bus.o_in_ready  = (state_q == IDLE);
  assign bus.o_ot_valid  = (state_q == DONE);
  assign bus.o_busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.o_ot_ci_acc = ot_acc;

endmodule

// File: tb/tb_cnn_ci_acc_seq.sv
// tb/tb_cnn_ci_acc_seq.sv - randomized bench with a behavioural tile model for a default
// and a 1-channel 3x3 accumulator; honours CNN_CI_ACC_RELU_EN.
module tb_cnn_ci_acc_seq;
  localparam int AICH = 4, AIX = 7, AIY = 4, K = 3, DL = 8, AL = 24;
  localparam int AOX = 5, AOY = 2, ANWIN = 40;
  localparam int BIX = 3, BIY = 3, BNWIN = 1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cnn_ci_acc_seq_if #(.ICH(AICH), .IX(AIX), .IY(AIY), .KX(K), .KY(K), .DATA_LEN(DL), .ACC_LEN(AL)) ifa();
  cnn_ci_acc_seq_if #(.ICH(1), .IX(BIX), .IY(BIY), .KX(K), .KY(K), .DATA_LEN(DL), .ACC_LEN(AL)) ifb();

  cnn_ci_acc_seq #(.ICH(AICH), .IX(AIX), .IY(AIY), .KX(K), .KY(K), .DATA_LEN(DL), .ACC_LEN(AL))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  cnn_ci_acc_seq #(.ICH(1), .IX(BIX), .IY(BIY), .KX(K), .KY(K), .DATA_LEN(DL), .ACC_LEN(AL))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int fa [AICH][AIY][AIX];
  int wa [AICH][K][K];
  int fb [BIY][BIX];
  int wb [K][K];
  int exp_a [AOY][AOX];
  int exp_b;
  int ph [2];
  int cnt [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int wrap_relu(input longint s);
    logic signed [AL-1:0] t;
    t = s[AL-1:0];
`ifdef CNN_CI_ACC_RELU_EN
    if (t < 0) t = '0;
`endif
    return int'(t);
  endfunction

  task automatic model_a();
    longint s;
    for (int y = 0; y < AOY; y++)
      for (int x = 0; x < AOX; x++) begin
        s = 0;
        for (int c = 0; c < AICH; c++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              s += longint'(fa[c][y+ky][x+kx]) * longint'(wa[c][ky][kx]);
        exp_a[y][x] = wrap_relu(s);
      end
  endtask

  task automatic model_b();
    longint s = 0;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        s += longint'(fb[ky][kx]) * longint'(wb[ky][kx]);
    exp_b = wrap_relu(s);
  endtask

  function automatic int elem_a(input int y, input int x);
    logic signed [AL-1:0] t;
    t = ifa.o_ot_ci_acc[(y*AOX+x)*AL +: AL];
    return int'(t);
  endfunction

  function automatic int elem_b();
    logic signed [AL-1:0] t;
    t = ifb.o_ot_ci_acc;
    return int'(t);
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic step(input int d, input logic srst, input logic iv, input logic orr, input int nw);
    if (srst) ph[d] = 0;
    else case (ph[d])
      0: if (iv) begin
        ph[d] = 1; cnt[d] = 0;
        if (d == 0) model_a(); else model_b();
      end
      1: begin
        cnt[d]++;
        if (cnt[d] == nw + 2) ph[d] = 2;
      end
      default: if (orr) ph[d] = 0;
    endcase
  endtask

  // Every cycle: outputs must match what the tile model says the block is doing.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_a_in_ready", ifa.o_in_ready, 1);
      chk("rst_a_valid", ifa.o_ot_valid, 0);
      chk("rst_a_busy", ifa.o_busy, 0);
      chk("rst_a_data", int'(ifa.o_ot_ci_acc != '0), 0);
      chk("rst_b_in_ready", ifb.o_in_ready, 1);
      chk("rst_b_valid", ifb.o_ot_valid, 0);
      chk("rst_b_data", int'(ifb.o_ot_ci_acc != '0), 0);
      ph[0] = 0; ph[1] = 0;
    end else begin
      chk("a_in_ready", ifa.o_in_ready, int'(ph[0] == 0));
      chk("a_valid", ifa.o_ot_valid, int'(ph[0] == 2));
      chk("a_busy", ifa.o_busy, int'(ph[0] == 1));
      chk("b_in_ready", ifb.o_in_ready, int'(ph[1] == 0));
      chk("b_valid", ifb.o_ot_valid, int'(ph[1] == 2));
      chk("b_busy", ifb.o_busy, int'(ph[1] == 1));
      if (ph[0] == 2)
        for (int y = 0; y < AOY; y++)
          for (int x = 0; x < AOX; x++)
            chk($sformatf("a_r%0d%0d", y, x), elem_a(y, x), exp_a[y][x]);
      if (ph[1] == 2) chk("b_r", elem_b(), exp_b);
      step(0, ifa.i_soft_reset, ifa.i_in_valid, ifa.i_ot_ready, ANWIN);
      step(1, ifb.i_soft_reset, ifb.i_in_valid, ifb.i_ot_ready, BNWIN);
    end
  end

  task automatic fill_a(input int mode);
    for (int c = 0; c < AICH; c++) begin
      for (int y = 0; y < AIY; y++)
        for (int x = 0; x < AIX; x++)
          fa[c][y][x] = (mode == 0) ? 1 : (mode == 1) ? x : (mode == 2) ? -128 : rnd8();
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          wa[c][ky][kx] = (mode == 0) ? 1 : (mode == 1) ? int'(ky == 0 && kx == 0) :
                          (mode == 2) ? 127 : rnd8();
    end
    for (int c = 0; c < AICH; c++) begin
      for (int y = 0; y < AIY; y++)
        for (int x = 0; x < AIX; x++)
          ifa.i_in_fmap[((c*AIY+y)*AIX+x)*DL +: DL] = DL'(fa[c][y][x]);
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          ifa.i_cnn_weight[((c*K+ky)*K+kx)*DL +: DL] = DL'(wa[c][ky][kx]);
    end
  endtask

  task automatic fill_b(input int mode);
    for (int y = 0; y < BIY; y++)
      for (int x = 0; x < BIX; x++) begin
        fb[y][x] = (mode == 0) ? 2 : rnd8();
        wb[y][x] = (mode == 0) ? 2 : rnd8();
        ifb.i_in_fmap[(y*BIX+x)*DL +: DL]    = DL'(fb[y][x]);
        ifb.i_cnn_weight[(y*K+x)*DL +: DL]   = DL'(wb[y][x]);
      end
  endtask

  // Sends the already-filled A tile, checks latency and optional literal results, then drains.
  task automatic send_a(input int hold, input bit pin, input int r00, input int r02, input int r14);
    int tx, n;
    @(posedge clk); #1 ifa.i_in_valid = 1'b1;
    @(negedge clk); tx = cyc; chk("a_xfer_ready", ifa.o_in_ready, 1);
    @(posedge clk); #1 ifa.i_in_valid = 1'b0;
    n = 0;
    while (!ifa.o_ot_valid && n < 200) begin @(negedge clk); n++; end
    if (!ifa.o_ot_valid) begin chk("a_timeout", 0, 1); return; end
    chk("a_latency", cyc - tx, 43);
    if (pin) begin
      chk("a_lit_r00", elem_a(0, 0), r00);
      chk("a_lit_r02", elem_a(0, 2), r02);
      chk("a_lit_r14", elem_a(1, 4), r14);
      chk("model_r00", exp_a[0][0], r00);
      chk("model_r14", exp_a[1][4], r14);
    end
    @(posedge clk); #1;
    repeat (hold) @(posedge clk);
    #1;
    if (hold > 0) begin
      chk("hold_valid", ifa.o_ot_valid, 1);
      chk("hold_in_ready", ifa.o_in_ready, 0);
      if (pin) chk("hold_r14", elem_a(1, 4), r14);
    end
    ifa.i_ot_ready = 1'b1;
    @(posedge clk); #1 ifa.i_ot_ready = 1'b0;
    @(negedge clk);
    chk("a_release_in_ready", ifa.o_in_ready, 1);
    chk("a_release_valid", ifa.o_ot_valid, 0);
  endtask

  task automatic send_b(input int hold, input bit pin, input int r);
    int tx, n;
    @(posedge clk); #1 ifb.i_in_valid = 1'b1;
    @(negedge clk); tx = cyc;
    @(posedge clk); #1 ifb.i_in_valid = 1'b0;
    n = 0;
    while (!ifb.o_ot_valid && n < 50) begin @(negedge clk); n++; end
    if (!ifb.o_ot_valid) begin chk("b_timeout", 0, 1); return; end
    chk("b_latency", cyc - tx, 4);
    if (pin) begin
      chk("b_lit_r", elem_b(), r);
      chk("model_b", exp_b, r);
    end
    @(posedge clk); #1;
    repeat (hold) @(posedge clk);
    #1 ifb.i_ot_ready = 1'b1;
    @(posedge clk); #1 ifb.i_ot_ready = 1'b0;
  endtask

  task automatic abort_a(input bit use_async);
    fill_a(3);
    @(posedge clk); #1 ifa.i_in_valid = 1'b1; ifa.i_ot_ready = 1'b1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1 ifa.i_in_valid = 1'b0; ifa.i_ot_ready = 1'b0;
    if (use_async) begin
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    end else begin
      ifa.i_soft_reset = 1'b1;
      @(posedge clk); #1 ifa.i_soft_reset = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy", ifa.o_busy, 0);
    chk("abort_in_ready", ifa.o_in_ready, 1);
    repeat (50) @(negedge clk);
    chk("abort_no_stale_valid", ifa.o_ot_valid, 0);
    fill_a(0);
    send_a(0, 1'b1, 36, 36, 36);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int xf[$];
    reset = 1'b0;
    ph[0] = 0; ph[1] = 0; cnt[0] = 0; cnt[1] = 0;
    ifa.i_soft_reset = 0; ifa.i_in_valid = 0; ifa.i_ot_ready = 0; ifa.i_in_fmap = '0; ifa.i_cnn_weight = '0;
    ifb.i_soft_reset = 0; ifb.i_in_valid = 0; ifb.i_ot_ready = 0; ifb.i_in_fmap = '0; ifb.i_cnn_weight = '0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    fill_a(0);
    send_a(0, 1'b1, 36, 36, 36);
    fill_a(1);
    send_a(0, 1'b1, 0, 8, 16);
    fill_a(2);
`ifdef CNN_CI_ACC_RELU_EN
    send_a(20, 1'b1, 0, 0, 0);
`else
    send_a(20, 1'b1, -585216, -585216, -585216);
`endif

    // Soft reset wins over a simultaneous input handshake.
    @(posedge clk); #1 ifa.i_in_valid = 1'b1; ifa.i_soft_reset = 1'b1;
    @(posedge clk); #1 ifa.i_in_valid = 1'b0; ifa.i_soft_reset = 1'b0;
    @(negedge clk);
    chk("srst_prio_in_ready", ifa.o_in_ready, 1);
    chk("srst_prio_busy", ifa.o_busy, 0);

    abort_a(1'b0);
    abort_a(1'b1);

    for (int i = 0; i < 6; i++) begin
      fill_a(3);
      send_a(int'($urandom_range(0, 4)), 1'b0, 0, 0, 0);
    end

    fill_b(0);
    send_b(0, 1'b1, 36);

    @(posedge clk); #1 ifb.i_in_valid = 1'b1; ifb.i_ot_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifb.i_in_valid && ifb.o_in_ready) xf.push_back(cyc);
    end
    @(posedge clk); #1 ifb.i_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 ifb.i_ot_ready = 1'b0;
    chk("b2b_count", int'(xf.size() >= 5), 1);
    for (int i = 1; i < xf.size(); i++) chk("b2b_period", xf[i] - xf[i-1], 5);

    for (int i = 0; i < 6; i++) begin
      fill_b(1);
      send_b(int'($urandom_range(0, 3)), 1'b0, 0);
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
